gat_bram_load_ctrl: RTL

- Host-side sequencer in front of the GAT accelerator top.
- Takes one 32-bit word stream from the DMA/PS side and writes it, in fixed order, into the H data, H node-info, weight and subgraph-index BRAM ports. Drives the per-BRAM load_done flags, then waits for gat_ready.
- Streams the new-feature BRAM back out with valid/ready backpressure.
- Generates byte addresses in word steps of 4, matching the accelerator's BRAM ports.

---
 rtl/gat_bram_load_ctrl.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/gat_bram_load_ctrl.sv
// Host-side sequencer for the GAT accelerator: loads four BRAMs from one word stream, waits for gat_ready, streams the feature BRAM back.
// Optional RUN-phase cycle counter enabled by defining GAT_RUN_CYCLE_CNT_EN.
module gat_bram_load_ctrl #(
  parameter int TOP_WIDTH          = 32,
  parameter int H_DATA_DEPTH       = 242101,
  parameter int NODE_INFO_DEPTH    = 13264,
  parameter int WEIGHT_DEPTH       = 22928,
  parameter int SUBGRAPH_IDX_DEPTH = 13264,
  parameter int NEW_FEATURE_DEPTH  = 43328,
  parameter int ADDR_W             = 20,
  parameter int RD_LAT             = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [TOP_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [TOP_WIDTH-1:0] bram_din,
  output logic                 bram_wea,
  output logic [ADDR_W-1:0]    bram_addra,
  output logic                 h_data_bram_ena,
  output logic                 h_node_info_bram_ena,
  output logic                 wgt_bram_ena,
  output logic                 subgraph_bram_ena,
  output logic                 h_data_bram_load_done,
  output logic                 h_node_info_bram_load_done,
  output logic                 wgt_bram_load_done,
  input  logic                 gat_ready,
  output logic [ADDR_W-1:0]    feat_bram_addrb,
  input  logic [TOP_WIDTH-1:0] feat_bram_dout,
  output logic [TOP_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          run_cycles
);

  localparam int MAX_A     = (H_DATA_DEPTH > NODE_INFO_DEPTH) ? H_DATA_DEPTH : NODE_INFO_DEPTH;
  localparam int MAX_B     = (WEIGHT_DEPTH > SUBGRAPH_IDX_DEPTH) ? WEIGHT_DEPTH : SUBGRAPH_IDX_DEPTH;
  localparam int MAX_C     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_DEPTH = (MAX_C > NEW_FEATURE_DEPTH) ? MAX_C : NEW_FEATURE_DEPTH;
  localparam int CNT_W     = $clog2(MAX_DEPTH) + 1;
  localparam int LAT_W     = $clog2(RD_LAT + 1) + 1;

  typedef enum logic [3:0] {
    IDLE, LD_H, LD_NI, LD_WGT, LD_SUB, RUN, RD_ISSUE, RD_WAIT, RD_OUT, DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
  logic [TOP_WIDTH-1:0]   din_q, din_d;
  logic                   wea_q, wea_d;
  logic [ADDR_W-1:0]      addra_q, addra_d;
  logic [3:0]             ena_q, ena_d;
  logic                   last_q, last_d;
  logic [2:0]             ld_done_q, ld_done_d;
  logic [TOP_WIDTH-1:0]   m_data_q, m_data_d;
  logic                   m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]      addrb_q, addrb_d;

  logic                   beat;
  logic [CNT_W-1:0]       tgt_last;
  logic [3:0]             tgt_sel;
  state_e                 tgt_next;

  function automatic logic [ADDR_W-1:0] to_addr(input logic [CNT_W-1:0] cnt);
    logic [CNT_W+1:0] byte_addr;
    byte_addr = {cnt, 2'b00};
    return ADDR_W'(byte_addr);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      rd_cnt_q   <= '0;
      lat_cnt_q  <= '0;
      din_q      <= '0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      ena_q      <= '0;
      last_q     <= 1'b0;
      ld_done_q  <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      addrb_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      din_q      <= din_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      ena_q      <= ena_d;
      last_q     <= last_d;
      ld_done_q  <= ld_done_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      addrb_q    <= addrb_d;
    end
  end

  always_comb begin
    tgt_last = CNT_W'(H_DATA_DEPTH - 1);
    tgt_sel  = 4'b0001;
    tgt_next = LD_NI;
    case (state_q)
      LD_NI: begin
        tgt_last = CNT_W'(NODE_INFO_DEPTH - 1);
        tgt_sel  = 4'b0010;
        tgt_next = LD_WGT;
      end
      LD_WGT: begin
        tgt_last = CNT_W'(WEIGHT_DEPTH - 1);
        tgt_sel  = 4'b0100;
        tgt_next = LD_SUB;
      end
      LD_SUB: begin
        tgt_last = CNT_W'(SUBGRAPH_IDX_DEPTH - 1);
        tgt_sel  = 4'b1000;
        tgt_next = RUN;
      end
      default: ;
    endcase
  end

  assign beat = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    din_d      = din_q;
    wea_d      = 1'b0;
    addra_d    = addra_q;
    ena_d      = '0;
    last_d     = 1'b0;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    addrb_d    = addrb_q;
    // A flag rises the cycle after the final write of its BRAM is on the port
    ld_done_d  = ld_done_q | ({3{last_q}} & ena_q[2:0]);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LD_H;
          ld_done_d  = '0;
          word_cnt_d = '0;
          rd_cnt_d   = '0;
        end
      end
      LD_H, LD_NI, LD_WGT, LD_SUB: begin
        if (beat) begin
          din_d   = s_data;
          addra_d = to_addr(word_cnt_q);
          wea_d   = 1'b1;
          ena_d   = tgt_sel;
          if (word_cnt_q == tgt_last) begin
            last_d     = 1'b1;
            word_cnt_d = '0;
            state_d    = tgt_next;
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (gat_ready) state_d = RD_ISSUE;
      end
      RD_ISSUE: begin
        addrb_d   = to_addr(rd_cnt_q);
        lat_cnt_d = '0;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        // One extra cycle beyond RD_LAT so the address has been registered by the BRAM
        if (lat_cnt_q == LAT_W'(RD_LAT)) begin
          m_data_d  = feat_bram_dout;
          m_valid_d = 1'b1;
          state_d   = RD_OUT;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      RD_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (rd_cnt_q == CNT_W'(NEW_FEATURE_DEPTH - 1)) begin
            state_d = DONE;
          end else begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
            state_d  = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      ld_done_d  = '0;
      word_cnt_d = '0;
      rd_cnt_d   = '0;
      lat_cnt_d  = '0;
      m_valid_d  = 1'b0;
      wea_d      = 1'b0;
      ena_d      = '0;
      last_d     = 1'b0;
    end
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      LD_H, LD_NI, LD_WGT, LD_SUB: s_ready = 1'b1;
      IDLE: busy = 1'b0;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bram_din                   = din_q;
  assign bram_wea                   = wea_q;
  assign bram_addra                 = addra_q;
  assign h_data_bram_ena            = ena_q[0];
  assign h_node_info_bram_ena       = ena_q[1];
  assign wgt_bram_ena               = ena_q[2];
  assign subgraph_bram_ena          = ena_q[3];
  assign h_data_bram_load_done      = ld_done_q[0];
  assign h_node_info_bram_load_done = ld_done_q[1];
  assign wgt_bram_load_done         = ld_done_q[2];
  assign feat_bram_addrb            = addrb_q;
  assign m_data                     = m_data_q;
  assign m_valid                    = m_valid_q;

`ifdef GAT_RUN_CYCLE_CNT_EN
  logic [31:0] run_cycles_q, run_cycles_d;

  always_comb begin
    run_cycles_d = run_cycles_q;
    if (abort || (start && (state_q == IDLE || state_q == DONE))) begin
      run_cycles_d = '0;
    end else if (state_q == RUN && run_cycles_q != '1) begin
      run_cycles_d = run_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_cycles_q <= '0;
    else        run_cycles_q <= run_cycles_d;
  end

  assign run_cycles = run_cycles_q;
`else
  assign run_cycles = '0;
`endif

endmodule
